// File: rtl/receptor_serial_pkg.sv
// receptor_serial_pkg
// Shared definitions for the serial receiver:
//   - state_e : receiver FSM encoding (3-bit)
//   - DirMsbFirst / DirLsbFirst : bit-order encoding shared with the transmitter
//     (0 = transmitter shifts left, MSB first; 1 = shifts right, LSB first)
package receptor_serial_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StData  = 3'd1,
        StPar   = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } state_e;

    localparam logic DirMsbFirst = 1'b0;
    localparam logic DirLsbFirst = 1'b1;

endpackage

// File: rtl/receptor_serial_if.sv
// receptor_serial_if
// Output side of the serial receiver: buffered word with valid/ready handshake
// plus one-cycle error pulses.
//   q         : received word, held while valid=1
//   valid     : q holds an unconsumed word
//   ready     : consumer accepts q on edges where valid & ready
//   err_frame : pulse, stop bit sampled 0
//   err_par   : pulse, parity mismatch (always 0 without parity support)
//   overrun   : pulse, completed word dropped because the buffer was full
// Modports: master = receiver side, slave = consumer side.
interface receptor_serial_if #(
    parameter int unsigned N = 4
) ();

    logic [N-1:0] q;
    logic         valid;
    logic         ready;
    logic         err_frame;
    logic         err_par;
    logic         overrun;

    modport master (
        output q,
        output valid,
        output err_frame,
        output err_par,
        output overrun,
        input  ready
    );

    modport slave (
        input  q,
        input  valid,
        input  err_frame,
        input  err_par,
        input  overrun,
        output ready
    );

endinterface

// File: rtl/receptor_serial_desplazador_entrada.sv
// receptor_serial_desplazador_entrada
// N-bit serial-in shift register for the receiver.
//   clk  : clock
//   rst  : synchronous active-high reset, clears the register
//   enb  : shift enable, one bit per enabled edge
//   dir  : DirMsbFirst shifts left (first bit ends in N-1),
//          DirLsbFirst shifts right (first bit ends in 0)
//   s_in : serial input
//   sh   : parallel register contents
module receptor_serial_desplazador_entrada
    import receptor_serial_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enb,
    input  logic         dir,
    input  logic         s_in,
    output logic [N-1:0] sh
);

    logic [N-1:0] sh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else if (enb) begin
            case (dir)
                DirMsbFirst: sh_q <= {sh_q[N-2:0], s_in};
                DirLsbFirst: sh_q <= {s_in, sh_q[N-1:1]};
            endcase
        end
    end

    assign sh = sh_q;

endmodule

// File: rtl/receptor_serial.sv
// receptor_serial
// Serial-to-parallel receiver for a framed bit stream:
//   start (0), N data bits, [even parity bit], stop (1).
// One frame element is sampled per clock edge with enb=1. The received word is
// presented on a single-entry buffer with a valid/ready handshake; framing,
// parity and overrun errors are reported as one-clock pulses.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, aborts any frame without error pulses
//   enb  : bit strobe
//   dir  : bit order (DirMsbFirst / DirLsbFirst), latched at the start bit
//   s_in : serial line, idle high
//   rx   : receptor_serial_if.master (q, valid, ready, err_frame, err_par, overrun)
//
// Configuration macro: RECEPTOR_SERIAL_PARITY_EN
//   defined   -> frame carries an even-parity bit, mismatches drop the word
//   undefined -> no parity bit, err_par tied to 0
module receptor_serial
    import receptor_serial_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             dir,
    input  logic             s_in,
    receptor_serial_if.master rx
);

    localparam int unsigned    CntW    = (N > 2) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            dir_q;
    logic [N-1:0]    sh;
    logic            shift_en;

    logic [N-1:0]    q_q;
    logic            valid_q;
    logic            err_frame_q;
    logic            overrun_q;
`ifdef RECEPTOR_SERIAL_PARITY_EN
    logic            err_par_q;
    logic            par_bad_q;
`endif

    // Data bits are shifted only on strobes while in DATA.
    assign shift_en = enb && (state_q == StData);

    receptor_serial_desplazador_entrada #(
        .N (N)
    ) u_desplazador (
        .clk  (clk),
        .rst  (rst),
        .enb  (shift_en),
        .dir  (dir_q),
        .s_in (s_in),
        .sh   (sh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dir_q       <= DirMsbFirst;
            q_q         <= '0;
            valid_q     <= 1'b0;
            err_frame_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef RECEPTOR_SERIAL_PARITY_EN
            err_par_q   <= 1'b0;
            par_bad_q   <= 1'b0;
`endif
        end else begin
            // Pulses last exactly one clock regardless of enb.
            err_frame_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef RECEPTOR_SERIAL_PARITY_EN
            err_par_q   <= 1'b0;
`endif

            // Consumption runs every clock; a delivery below on the same edge
            // overrides this clear.
            if (valid_q && rx.ready) begin
                valid_q <= 1'b0;
            end

            if (enb) begin
                case (state_q)
                    StIdle: begin
                        if (!s_in) begin
                            dir_q   <= dir;
                            cnt_q   <= '0;
                            state_q <= StData;
                        end
                    end

                    StData: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CntLast) begin
`ifdef RECEPTOR_SERIAL_PARITY_EN
                            state_q <= StPar;
`else
                            state_q <= StStop;
`endif
                        end
                    end

`ifdef RECEPTOR_SERIAL_PARITY_EN
                    StPar: begin
                        // sh already holds all N data bits; even parity.
                        par_bad_q <= s_in ^ (^sh);
                        state_q   <= StStop;
                    end
`endif

                    StStop: begin
                        if (!s_in) begin
                            err_frame_q <= 1'b1;
                            state_q     <= StBreak;
                        end
`ifdef RECEPTOR_SERIAL_PARITY_EN
                        else if (par_bad_q) begin
                            err_par_q <= 1'b1;
                            state_q   <= StIdle;
                        end
`endif
                        else begin
                            if (!valid_q || rx.ready) begin
                                q_q     <= sh;
                                valid_q <= 1'b1;
                            end else begin
                                // Buffer full: keep old word, lose the new one.
                                overrun_q <= 1'b1;
                            end
                            state_q <= StIdle;
                        end
                    end

                    // A line held low after a bad stop must not look like a
                    // new start bit.
                    StBreak: begin
                        if (s_in) begin
                            state_q <= StIdle;
                        end
                    end

                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign rx.q         = q_q;
    assign rx.valid     = valid_q;
    assign rx.err_frame = err_frame_q;
    assign rx.overrun   = overrun_q;
`ifdef RECEPTOR_SERIAL_PARITY_EN
    assign rx.err_par   = err_par_q;
`else
    assign rx.err_par   = 1'b0;
`endif

endmodule

// File: tb/tb_receptor_serial.sv
// tb_receptor_serial
// Directed bench for receptor_serial with N=4. Inputs change 1 time unit after
// the rising edge; outputs are sampled at the same point.
module tb_receptor_serial;

    logic clk;
    logic rst;
    logic enb;
    logic dir;
    logic s_in;

    int unsigned n_checks;
    int unsigned n_fail;

    receptor_serial_if #(.N(4)) rx_if ();

    receptor_serial #(
        .N (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .enb  (enb),
        .dir  (dir),
        .s_in (s_in),
        .rx   (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame element; with stride > 1 the strobe is preceded by idle cycles.
    task automatic send_bit(input logic b, input int stride);
        if (stride > 1) begin
            enb  = 1'b0;
            s_in = b;
            repeat (stride - 1) tick();
        end
        enb  = 1'b1;
        s_in = b;
        tick();
    endtask

    // d[3] is the first data bit on the line.
    task automatic send_frame(input logic [3:0] d, input logic stop_bit, input int stride);
        send_bit(1'b0, stride);
        for (int i = 3; i >= 0; i--) send_bit(d[i], stride);
`ifdef RECEPTOR_SERIAL_PARITY_EN
        send_bit(^d, stride);
`endif
        send_bit(stop_bit, stride);
    endtask

    task automatic idle(input int n);
        enb  = 1'b1;
        s_in = 1'b1;
        repeat (n) tick();
    endtask

    task automatic consume();
        rx_if.ready = 1'b1;
        idle(1);
        rx_if.ready = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        enb         = 1'b0;
        dir         = 1'b0;
        s_in        = 1'b1;
        rx_if.ready = 1'b0;
        repeat (2) tick();
        check("rst_q", rx_if.q, 4'b0000);
        check("rst_valid", rx_if.valid, 0);
        check("rst_err_frame", rx_if.err_frame, 0);
        check("rst_err_par", rx_if.err_par, 0);
        check("rst_overrun", rx_if.overrun, 0);
        rst = 1'b0;
        idle(1);

        // 1: MSB first, word appears right after the stop sample.
        dir = 1'b0;
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b1, 1);
`ifdef RECEPTOR_SERIAL_PARITY_EN
        send_bit(1'b1, 1);
`endif
        check("t1_valid_before_stop", rx_if.valid, 0);
        send_bit(1'b1, 1);
        check("t1_q", rx_if.q, 4'b1011);
        check("t1_valid", rx_if.valid, 1);
        check("t1_err_frame", rx_if.err_frame, 0);
        check("t1_err_par", rx_if.err_par, 0);
        check("t1_overrun", rx_if.overrun, 0);
        idle(1);
        check("t1_valid_held", rx_if.valid, 1);
        consume();
        check("t1_consumed_valid", rx_if.valid, 0);
        check("t1_consumed_q", rx_if.q, 4'b1011);

        // 2: LSB first; dir flipped after the start bit must be ignored.
        dir = 1'b1;
        send_bit(1'b0, 1);
        dir = 1'b0;
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b1, 1);
`ifdef RECEPTOR_SERIAL_PARITY_EN
        send_bit(1'b1, 1);
`endif
        send_bit(1'b1, 1);
        check("t2_q", rx_if.q, 4'b1101);
        check("t2_valid", rx_if.valid, 1);
        consume();
        check("t2_consumed_valid", rx_if.valid, 0);
        check("t2_consumed_q", rx_if.q, 4'b1101);

        // 3: bad stop bit, then a low line that must not start a frame.
        send_frame(4'b1111, 1'b0, 1);
        check("t3_err_frame", rx_if.err_frame, 1);
        check("t3_valid", rx_if.valid, 0);
        send_bit(1'b0, 1);
        check("t3_err_frame_one_clk", rx_if.err_frame, 0);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        idle(6);
        check("t3_no_false_frame", rx_if.valid, 0);
        check("t3_err_frame_quiet", rx_if.err_frame, 0);

        // 4: back-to-back frames, overrun then same-edge consume.
        send_frame(4'b1011, 1'b1, 1);
        check("t4_first_q", rx_if.q, 4'b1011);
        send_frame(4'b0110, 1'b1, 1);
        check("t4_overrun", rx_if.overrun, 1);
        check("t4_q_kept", rx_if.q, 4'b1011);
        check("t4_valid_kept", rx_if.valid, 1);
        idle(1);
        check("t4_overrun_one_clk", rx_if.overrun, 0);
        send_bit(1'b0, 1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
`ifdef RECEPTOR_SERIAL_PARITY_EN
        send_bit(1'b0, 1);
`endif
        rx_if.ready = 1'b1;
        send_bit(1'b1, 1);
        rx_if.ready = 1'b0;
        check("t4_replace_q", rx_if.q, 4'b0110);
        check("t4_replace_valid", rx_if.valid, 1);
        check("t4_replace_overrun", rx_if.overrun, 0);

        // 5: reset mid-frame clears everything; next frame is clean.
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        rst  = 1'b1;
        s_in = 1'b0;
        tick();
        rst = 1'b0;
        check("t5_rst_q", rx_if.q, 4'b0000);
        check("t5_rst_valid", rx_if.valid, 0);
        check("t5_rst_err_frame", rx_if.err_frame, 0);
        check("t5_rst_overrun", rx_if.overrun, 0);
        send_frame(4'b0110, 1'b1, 1);
        check("t5_q", rx_if.q, 4'b0110);
        check("t5_valid", rx_if.valid, 1);
        consume();

        // 6: strobe every other cycle.
        send_frame(4'b1011, 1'b1, 2);
        check("t6_q", rx_if.q, 4'b1011);
        check("t6_valid", rx_if.valid, 1);
        check("t6_err_par", rx_if.err_par, 0);
        consume();
        send_frame(4'b0110, 1'b0, 2);
        check("t6_err_frame", rx_if.err_frame, 1);
        enb = 1'b0;
        tick();
        check("t6_err_frame_enb_low", rx_if.err_frame, 0);
        send_bit(1'b1, 2);
        idle(2);
        check("t6_valid_after_break", rx_if.valid, 0);
`ifdef RECEPTOR_SERIAL_PARITY_EN
        send_bit(1'b0, 2);
        send_bit(1'b1, 2);
        send_bit(1'b0, 2);
        send_bit(1'b1, 2);
        send_bit(1'b1, 2);
        send_bit(1'b0, 2);
        send_bit(1'b1, 2);
        check("t6_err_par", rx_if.err_par, 1);
        check("t6_par_valid", rx_if.valid, 0);
        enb = 1'b0;
        tick();
        check("t6_err_par_one_clk", rx_if.err_par, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
